// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared pipeline types for the instruction-fetch stage
package fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_WAIT  = 2'd2
    } fetch_state;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction-memory request/grant/rvalid bus
interface fetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetched {pc, instruction} entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          n_rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  fetch_entry    wdata_i,
    output fetch_entry    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push into a full FIFO is only accepted alongside a pop, so live entries are never overwritten.
    assign w_push  = push_i & (~full_o | pop_i);
    assign w_pop   = pop_i & ~empty_o;
    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i) r_mem[r_wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction-fetch stage: PC, one-outstanding imem reads, output FIFO, redirect
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        n_rst,
    fetch_if.master     imem,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    localparam int         CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] ST_IDLE  = FS_IDLE;
    localparam logic [1:0] ST_FETCH = FS_FETCH;
    localparam logic [1:0] ST_WAIT  = FS_WAIT;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_discard;

    logic          w_rvalid_wait;
    logic          w_push;
    logic          w_pop;
    logic          w_req;
    logic          w_gnt;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_count_next;
    fetch_entry    w_wentry;
    fetch_entry    w_head;

    assign w_rvalid_wait = (r_state == ST_WAIT) & imem.imem_rvalid_i;
    assign w_push        = w_rvalid_wait & ~r_discard & ~flush_i;
    assign w_pop         = ~w_fifo_empty & ~stall_i & ~flush_i;
    assign w_count_next  = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
    assign w_wentry      = '{pc: r_req_pc, instruction: imem.imem_rdata_i};

    // Back-to-back issue in WAIT keys off the post-cycle occupancy so a zero-wait memory streams one word per cycle.
    always_comb begin
        w_req = 1'b0;
        if (!flush_i) begin
            case (r_state)
                ST_FETCH: w_req = ~w_fifo_full;
                ST_WAIT:  w_req = imem.imem_rvalid_i & ~r_discard &
                                  (w_count_next < (CW+1)'(FIFO_DEPTH));
                default:  w_req = 1'b0;
            endcase
        end
    end

    assign w_gnt            = w_req & imem.imem_gnt_i;
    assign imem.imem_req_o  = w_req;
    assign imem.imem_addr_o = r_pc;

    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_req_pc  <= '0;
            r_discard <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= ST_FETCH;
                ST_FETCH: if (w_gnt) r_state <= ST_WAIT;
                ST_WAIT:  if (imem.imem_rvalid_i) r_state <= w_gnt ? ST_WAIT : ST_FETCH;
                default:  r_state <= ST_FETCH;
            endcase

            if (w_gnt) r_req_pc <= r_pc;

            if (flush_i)    r_pc <= {redirect_pc_i[31:2], 2'b00};
            else if (w_gnt) r_pc <= r_pc + 32'd4;

            // A flush with the response still in flight marks it stale; its rvalid is then swallowed.
            if (flush_i && (r_state == ST_WAIT) && !imem.imem_rvalid_i) r_discard <= 1'b1;
            else if (w_rvalid_wait)                                     r_discard <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .n_rst   (n_rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .clear_i (flush_i),
        .wdata_i (w_wentry),
        .rdata_o (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_count)
    );

    assign valid_o       = ~w_fifo_empty;
    assign instruction_o = w_fifo_empty ? NOP   : w_head.instruction;
    assign pc_o          = w_fifo_empty ? '0    : w_head.pc;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for fetch with a queue-level reference model
module tb_fetch;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk   = 1'b0;
    logic        n_rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;

    fetch_if imem_if();

    fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .n_rst         (n_rst),
        .imem          (imem_if),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the FIFO as a queue of delivered PCs plus a one-slot memory.
    logic [31:0] q[$];
    logic [31:0] f_pc;
    logic [31:0] m_addr;
    bit          m_pend, m_stale, first, rand_gnt, rand_lat;
    int          cyc, m_due, gnt_low, mem_lat;

    logic        o_req, o_hs, o_valid;
    logic [31:0] o_addr, o_pc;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        imem_if.imem_gnt_i    = 1'b0;
        imem_if.imem_rvalid_i = 1'b0;
        imem_if.imem_rdata_i  = '0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("rst valid_o", valid_o, 0);
        chk("rst pc_o", pc_o, 0);
        chk("rst instruction_o", instruction_o, NOP);
        chk("rst imem_req_o", imem_if.imem_req_o, 0);
        @(negedge clk);
        @(negedge clk);
        q.delete();
        f_pc = 32'h0; m_pend = 0; m_stale = 0; first = 1; cyc = 0;
        gnt_low = 0; rand_gnt = 0; rand_lat = 0; mem_lat = 1;
        n_rst = 1'b1;
    endtask

    task automatic cycle();
        logic rv, g, push, pop, ereq;
        int   post, occ;
        rv = m_pend && (cyc == m_due);
        if (gnt_low > 0) begin
            g = 1'b0;
            gnt_low--;
        end else begin
            g = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        imem_if.imem_gnt_i    = g;
        imem_if.imem_rvalid_i = rv;
        imem_if.imem_rdata_i  = rv ? (m_addr ^ KEY) : $urandom;
        #1;
        o_req   = imem_if.imem_req_o;
        o_addr  = imem_if.imem_addr_o;
        o_valid = valid_o;
        o_pc    = pc_o;
        push = rv && !m_stale && !flush_i;
        pop  = (q.size() > 0) && !stall_i && !flush_i;
        post = q.size() + int'(push) - int'(pop);
        occ  = rv ? post : q.size();
        ereq = !first && !flush_i && !(m_pend && !rv) && !(rv && m_stale) && (occ < DEPTH);
        chk("valid_o", valid_o, q.size() > 0);
        if (q.size() > 0) begin
            chk("pc_o", pc_o, q[0]);
            chk("instruction_o", instruction_o, q[0] ^ KEY);
        end else begin
            chk("pc_o", pc_o, 0);
            chk("instruction_o", instruction_o, NOP);
        end
        chk("imem_req_o", o_req, ereq);
        if (o_req && ereq) chk("imem_addr_o", o_addr, f_pc);
        chk("fifo overflow", dut.w_push & dut.w_fifo_full & ~dut.w_pop, 0);
        o_hs = o_req && g;
        if (rv) begin
            m_pend = 0;
            m_stale = 0;
        end
        if (flush_i) begin
            q.delete();
            f_pc = {redirect_pc_i[31:2], 2'b00};
            if (m_pend) m_stale = 1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(m_addr);
            if (o_hs) f_pc = f_pc + 32'd4;
        end
        if (o_hs) begin
            m_pend  = 1;
            m_stale = flush_i;
            m_due   = cyc + (rand_lat ? int'($urandom_range(1, 3)) : mem_lat);
            m_addr  = o_addr;
        end
        first = 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic next_hs(input int maxc, output logic [31:0] addr, output bit found);
        found = 0;
        addr  = '0;
        for (int i = 0; i < maxc && !found; i++) begin
            cycle();
            if (o_hs) begin
                found = 1;
                addr  = o_addr;
            end
        end
    endtask

    task automatic next_pop(input int maxc, output logic [31:0] pc, output bit found);
        found = 0;
        pc    = '0;
        for (int i = 0; i < maxc && !found; i++) begin
            cycle();
            if (o_valid && !stall_i && !flush_i) begin
                found = 1;
                pc    = o_pc;
            end
        end
    endtask

    initial begin
        vec_t        tbl[13];
        logic [31:0] a;
        bit          ok;

        tbl = '{
            '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0},
            '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0},
            '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0},
            '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0},
            '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0},
            '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0},
            '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0},
            '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0},
            '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0},
            '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0},
            '{1'b0, 1'b1, 32'h08, 1'b1, 32'h4},
            '{1'b0, 1'b1, 32'h0C, 1'b0, 32'h0},
            '{1'b0, 1'b1, 32'h10, 1'b1, 32'h8}
        };

        @(negedge clk);

        // Zero-wait streaming, then a six-cycle stall with the FIFO full.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            stall_i = tbl[i].stall;
            cycle();
            chk($sformatf("tbl[%0d] req", i), o_req, tbl[i].req);
            if (tbl[i].req) chk($sformatf("tbl[%0d] addr", i), o_addr, tbl[i].addr);
            chk($sformatf("tbl[%0d] valid", i), o_valid, tbl[i].valid);
            chk($sformatf("tbl[%0d] pc", i), o_pc, tbl[i].pc);
        end
        stall_i = 1'b0;

        // Flush coinciding with rvalid and a pop.
        do_reset();
        repeat (4) cycle();
        flush_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        cycle();
        chk("flush-cycle req", o_req, 0);
        chk("flush-cycle valid", o_valid, 1);
        flush_i = 1'b0;
        cycle();
        chk("post-flush valid", o_valid, 0);
        chk("post-flush req", o_req, 1);
        chk("post-flush addr", o_addr, 32'h200);
        next_pop(20, a, ok);
        chk("post-flush first pc", a, 32'h200);

        // Grant withheld for four cycles.
        do_reset();
        gnt_low = 5;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("gnt-hold[%0d] req", i), o_req, 1);
            chk($sformatf("gnt-hold[%0d] addr", i), o_addr, 32'h0);
        end
        cycle();
        chk("gnt-release hs", o_hs, 1);
        cycle();
        chk("gnt-release next addr", o_addr, 32'h4);

        // Three-cycle memory latency, redirect while 0x8 is outstanding.
        do_reset();
        mem_lat = 3;
        a = '1;
        ok = 1;
        for (int i = 0; i < 10 && ok && a != 32'h8; i++) next_hs(20, a, ok);
        chk("lat3 reached 0x8", a, 32'h8);
        flush_i = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        cycle();
        flush_i = 1'b0;
        next_hs(20, a, ok);
        chk("lat3 grant after flush found", ok, 1);
        chk("lat3 grant after flush", a, 32'h100);
        next_pop(20, a, ok);
        chk("lat3 first valid pc", a, 32'h100);

        // PC wrap at the top of the address space.
        do_reset();
        repeat (4) cycle();
        flush_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        cycle();
        flush_i = 1'b0;
        next_pop(20, a, ok);
        chk("wrap pc0", a, 32'hFFFF_FFFC);
        next_pop(20, a, ok);
        chk("wrap pc1", a, 32'h0);

        // Random traffic against the model, then an asynchronous reset mid-stream.
        do_reset();
        rand_gnt = 1;
        rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            stall_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom;
            cycle();
        end
        stall_i = 1'b0;
        flush_i = 1'b0;
        #2;
        do_reset();
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage. Sits directly upstream of the decode stage and drives its instruction_i/pc_i inputs.
- Owns the architectural PC and issues word reads on the instruction-memory request/grant/rvalid bus. Holds at most one request outstanding.
- Buffers returned words in a small FIFO so decode stalls do not cancel memory traffic. Handles redirect/flush from execute (branch/jump).

Parameters:
- RESET_PC, 32'h0000_0000, first PC fetched after reset.
- FIFO_DEPTH, 2, number of fetched {pc, instruction} entries buffered; legal values 2..8.

Ports:
- clk_i  in  1  clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- imem_req_o  out  1  read request to instruction memory.
- imem_addr_o  out  32  byte address of request, word aligned (bits [1:0] = 0).
- imem_gnt_i  in  1  request accepted this cycle (req & gnt = handshake).
- imem_rvalid_i  in  1  read data valid; exactly one per granted request, at earliest the cycle after grant.
- imem_rdata_i  in  32  instruction word.
- stall_i  in  1  decode/pipeline cannot accept an instruction this cycle.
- flush_i  in  1  redirect request from execute (taken branch/jump).
- redirect_pc_i  in  32  new PC, sampled when flush_i = 1; bits [1:0] ignored (forced 0).
- instruction_o  out  32  instruction to decode.
- pc_o  out  32  PC of instruction_o.
- valid_o  out  1  instruction_o/pc_o hold a real instruction.

Behaviour:
- Reset (async, n_rst = 0): state=IDLE, pc_q=RESET_PC, FIFO empty, discard flag=0, imem_req_o=0, valid_o=0, pc_o=0, instruction_o=32'h0000_0013 (NOP).
- FSM states:
  - IDLE: only the first cycle after reset release, then goes to FETCH. No request.
  - FETCH: no request outstanding. imem_req_o=1 iff FIFO count < FIFO_DEPTH. On req&gnt: latch req_pc=pc_q, pc_q<=pc_q+4, go to WAIT.
  - WAIT: one request outstanding, imem_req_o=0, except the back-to-back case below. When imem_rvalid_i=1:
    - Push {req_pc, imem_rdata_i} unless discard=1.
    - Clear discard.
    - Go to FETCH, or stay in WAIT if a back-to-back request is granted that cycle.
- Back-to-back: in WAIT, when imem_rvalid_i=1, discard=0, no flush, and post-cycle count (count + push - pop) < FIFO_DEPTH, assert imem_req_o the same cycle with addr=pc_q. This gives 1 instruction/cycle with a zero-wait memory.
- imem_addr_o = pc_q whenever imem_req_o=1.
- Once asserted without grant, imem_req_o and imem_addr_o must stay stable until granted. Exception: flush may change the address or drop the request.
- Output side:
  - valid_o = FIFO not empty. instruction_o/pc_o = FIFO head, else NOP/0.
  - Pop when valid_o & ~stall_i.
  - stall_i holds the head unchanged.
- Flush (flush_i=1), which has priority over every other event in the same cycle:
  - FIFO cleared, so valid_o=0 next cycle.
  - pc_q <= {redirect_pc_i[31:2],2'b00}.
  - Pop suppressed.
  - Outstanding request (WAIT with no rvalid this cycle, or grant this cycle): set discard=1 so the stale response is dropped.
  - rvalid arriving in the flush cycle: data dropped.
  - No new request is granted to the old PC in the flush cycle: imem_req_o is forced 0.
- FIFO full: no request issued. Entries are never overwritten. Push while full cannot happen by construction; verification asserts this.
- Simultaneous push and pop with count = FIFO_DEPTH: legal only via the back-to-back rule; count is unchanged.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Latency, zero-wait memory, no stall: the first valid_o occurs 3 cycles after reset release (IDLE, grant, rvalid->push, head visible).
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight response after reset release is the memory's responsibility: the memory bus is reset together with this block.

Decomposition:
- Shared pipeline package gains: the NOP constant (32'h0000_0013), a fetch_state enum (IDLE, FETCH, WAIT), and a fetch_entry struct {pc[31:0], instruction[31:0]}.
- One sub-module: fetch_fifo, a synchronous FIFO of fetch_entry with push, pop, clear, full, empty and count, parameterised by depth.

Test Plan:
- Reset release, zero-wait memory returning rdata=addr^32'hA5A5_0000, stall_i=0 -> grants at 0x0, 0x4, 0x8 on consecutive cycles; valid_o with pc_o 0x0, 0x4, 0x8 on consecutive cycles, instruction_o matching.
- Hold stall_i=1 for 6 cycles after the first valid -> exactly FIFO_DEPTH=2 entries buffered, imem_req_o=0 while full, head pc_o=0x0 stable. Release -> 0x0, 0x4, 0x8 in order, with no PC skipped or duplicated.
- Memory with 3-cycle rvalid latency, flush_i with redirect_pc_i=0x100 while a request to 0x8 is outstanding -> response for 0x8 dropped; next grant at 0x100; first valid pc_o=0x100.
- flush_i in the same cycle as rvalid and a pop -> the pushed word is dropped, FIFO is empty next cycle, imem_req_o=0 in the flush cycle.
- gnt held low for 4 cycles -> imem_req_o stays 1 and imem_addr_o stays 0x0 unchanged; advances only after the grant.
- redirect_pc_i=32'hFFFF_FFFE -> fetch at 0xFFFF_FFFC, then 0x0000_0000 (wrap); valid_o pc_o sequence 0xFFFF_FFFC, 0x0.
